branch_resv_station: RTL

- Parametrised branch reservation station with a comparator.
- Holds up to DEPTH conditional-branch micro-ops and snoops NCDB result-broadcast channels to wake pending operands.
- Issues the oldest ready entry each cycle: resolves the compare, computes next PC and reports the result to the ROB/fetch redirect logic.
- Adds over the previous generation: insert backpressure, oldest-first issue, a multi-channel CDB, same-cycle operand bypass, flush, and fall-through PC.

---
 rtl/branch_resv_station_if.sv | 41 ++++
 rtl/branch_resv_station.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/branch_resv_station_if.sv
// rtl/branch_resv_station_if.sv - dispatch, CDB snoop, flush and resolve bundle of the branch station
interface branch_resv_station_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 8,
  parameter int NCDB  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [TAG_W-1:0]       in_target;
  logic [XLEN-1:0]        in_val1;
  logic [XLEN-1:0]        in_val2;
  logic [TAG_W-1:0]       in_tag1;
  logic [TAG_W-1:0]       in_tag2;
  logic [XLEN-1:0]        in_pc;
  logic [XLEN-1:0]        in_offset;
  logic [2:0]             in_op;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*XLEN-1:0]   cdb_val;
  logic                   flush;
  logic                   out_valid;
  logic [TAG_W-1:0]       out_target;
  logic                   out_taken;
  logic [XLEN-1:0]        out_next_pc;
  logic [CW-1:0]          count;

  modport slave (
    input  in_valid, in_target, in_val1, in_val2, in_tag1, in_tag2, in_pc, in_offset, in_op,
    input  cdb_valid, cdb_tag, cdb_val, flush,
    output in_ready, out_valid, out_target, out_taken, out_next_pc, count
  );

  modport master (
    output in_valid, in_target, in_val1, in_val2, in_tag1, in_tag2, in_pc, in_offset, in_op,
    output cdb_valid, cdb_tag, cdb_val, flush,
    input  in_ready, out_valid, out_target, out_taken, out_next_pc, count
  );
endinterface

// File: rtl/branch_resv_station.sv
// rtl/branch_resv_station.sv - branch reservation station with CDB wakeup, oldest-first issue and comparator
module branch_resv_station #(
  parameter int               XLEN        = 32,
  parameter int               TAG_W       = 4,
  parameter int               DEPTH       = 8,
  parameter int               NCDB        = 2,
  parameter logic [TAG_W-1:0] TAG_INVALID = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resv_station_if.slave bus
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);
  localparam int OPW = TAG_W + XLEN;

  // older_q[i][j] set means entry j was inserted before entry i (age matrix, never overflows)
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] older_q  [DEPTH];
  logic [TAG_W-1:0] target_q [DEPTH];
  logic [TAG_W-1:0] tag1_q   [DEPTH];
  logic [TAG_W-1:0] tag2_q   [DEPTH];
  logic [XLEN-1:0]  val1_q   [DEPTH];
  logic [XLEN-1:0]  val2_q   [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  off_q    [DEPTH];
  logic [2:0]       op_q     [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic             out_valid_q, out_taken_q;
  logic [TAG_W-1:0] out_target_q;
  logic [XLEN-1:0]  out_next_pc_q;

  logic [TAG_W-1:0] tag1_d [DEPTH];
  logic [TAG_W-1:0] tag2_d [DEPTH];
  logic [XLEN-1:0]  val1_d [DEPTH];
  logic [XLEN-1:0]  val2_d [DEPTH];
  logic [DEPTH-1:0] ready;
  logic             iss_found;
  logic [IW-1:0]    iss_sel;
  logic             iss_taken;
  logic [XLEN-1:0]  iss_next_pc;
  logic             ins_fire;
  logic [IW-1:0]    ins_slot;
  logic [OPW-1:0]   byp1, byp2;

  // Returns {tag, value} after snooping the CDB; lowest matching channel wins
  function automatic logic [OPW-1:0] snoop(
    input logic [TAG_W-1:0]      tag,
    input logic [XLEN-1:0]       val,
    input logic [NCDB-1:0]       cv,
    input logic [NCDB*TAG_W-1:0] ct,
    input logic [NCDB*XLEN-1:0]  cd
  );
    logic [OPW-1:0] r;
    r = {tag, val};
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (cv[k] && (ct[k*TAG_W +: TAG_W] != TAG_INVALID) && (ct[k*TAG_W +: TAG_W] == tag))
        r = {TAG_INVALID, cd[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  // funct3 compare; undefined encodings fall through as not taken
  function automatic logic resolve_taken(input logic [2:0] op, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign bus.in_ready    = (count_q < CW'(DEPTH));
  assign bus.count       = count_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_target  = out_target_q;
  assign bus.out_taken   = out_taken_q;
  assign bus.out_next_pc = out_next_pc_q;

  assign ins_fire    = bus.in_valid && bus.in_ready && !bus.flush;
  assign byp1        = snoop(bus.in_tag1, bus.in_val1, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
  assign byp2        = snoop(bus.in_tag2, bus.in_val2, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
  assign iss_taken   = resolve_taken(op_q[iss_sel], val1_q[iss_sel], val2_q[iss_sel]);
  assign iss_next_pc = iss_taken ? (pc_q[iss_sel] + off_q[iss_sel]) : (pc_q[iss_sel] + XLEN'(4));
  assign count_d     = count_q + CW'(ins_fire) - CW'(iss_found);

  // Wakeup of resident operands and pre-edge readiness
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {tag1_d[i], val1_d[i]} = snoop(tag1_q[i], val1_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      {tag2_d[i], val2_d[i]} = snoop(tag2_q[i], val2_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      ready[i] = valid_q[i] && (tag1_q[i] == TAG_INVALID) && (tag2_q[i] == TAG_INVALID);
    end
  end

  // Oldest ready entry: ready with no older ready entry
  always_comb begin
    iss_found = 1'b0;
    iss_sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && ((ready & older_q[i]) == '0)) begin
        iss_found = 1'b1;
        iss_sel   = IW'(i);
      end
    end
  end

  // Lowest-index free slot for insertion
  always_comb begin
    ins_slot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) ins_slot = IW'(i);
    end
  end

  // Entry storage, age matrix, occupancy and registered resolve output
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_target_q  <= TAG_INVALID;
      out_taken_q   <= 1'b0;
      out_next_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else if (bus.flush) begin
      valid_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= iss_found;
      if (iss_found) begin
        out_target_q     <= target_q[iss_sel];
        out_taken_q      <= iss_taken;
        out_next_pc_q    <= iss_next_pc;
        valid_q[iss_sel] <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        tag1_q[i] <= tag1_d[i];
        val1_q[i] <= val1_d[i];
        tag2_q[i] <= tag2_d[i];
        val2_q[i] <= val2_d[i];
      end
      if (ins_fire) begin
        valid_q[ins_slot]  <= 1'b1;
        target_q[ins_slot] <= bus.in_target;
        {tag1_q[ins_slot], val1_q[ins_slot]} <= byp1;
        {tag2_q[ins_slot], val2_q[ins_slot]} <= byp2;
        pc_q[ins_slot]     <= bus.in_pc;
        off_q[ins_slot]    <= bus.in_offset;
        op_q[ins_slot]     <= bus.in_op;
        for (int j = 0; j < DEPTH; j++) begin
          older_q[j][ins_slot] <= 1'b0;
          older_q[ins_slot][j] <= valid_q[j];
        end
      end
    end
  end
endmodule
